// File: rtl/debug_pkg.sv
// Shared types and constants for the UART debug command controller.
package debug_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_IDLE     = 4'd1,
    ST_DECODE   = 4'd2,
    ST_ARG      = 4'd3,
    ST_STEPPING = 4'd4,
    ST_RUNNING  = 4'd5,
    ST_SOFT_RST = 4'd6,
    ST_SEND     = 4'd7
  } dbg_state_e;

  typedef enum logic [2:0] {
    STAT_OK         = 3'd0,
    STAT_FINISHED   = 3'd1,
    STAT_BREAKPOINT = 3'd2,
    STAT_TIMEOUT    = 3'd3,
    STAT_UNKNOWN    = 3'd4
  } dbg_status_e;

  localparam logic [7:0] CMD_STEP_DEF  = 8'h31;
  localparam logic [7:0] CMD_RUN_DEF   = 8'h32;
  localparam logic [7:0] CMD_RESET_DEF = 8'h33;
  localparam logic [7:0] CMD_STEPN_DEF = 8'h34;
  localparam logic [7:0] CMD_SETBP_DEF = 8'h35;
  localparam logic [7:0] CMD_CLRBP_DEF = 8'h36;

  function automatic int bytes_for(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_cmd_ctrl_if.sv
// UART byte stream and dump-transmit handshake; master is the UART side,
// slave is the debug controller.
interface debug_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rd_uart;
  logic       send_req;
  logic       tx_done;

  modport master (output rx_data, rx_ready, tx_done, input rd_uart, send_req);
  modport slave  (input rx_data, rx_ready, tx_done, output rd_uart, send_req);
endinterface

// File: rtl/debug_arg_shift.sv
// Little-endian argument assembler: the first byte taken lands in bits [7:0].
module debug_arg_shift #(
  parameter  int NBYTES = 4,
  localparam int CW     = $clog2(NBYTES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic [7:0]          byte_i,
  input  logic [CW-1:0]       nbytes_i,
  output logic [8*NBYTES-1:0] value_o,
  output logic                done_o
);

  logic [8*NBYTES-1:0] val_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      val_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (shift_i && !done_q) begin
      for (int b = 0; b < NBYTES; b++)
        if (cnt_q == CW'(b)) val_q[8*b +: 8] <= byte_i;
      cnt_q  <= cnt_q + CW'(1);
      done_q <= (cnt_q + CW'(1)) == nbytes_i;
    end
  end

  assign value_o = val_q;
  assign done_o  = done_q;

endmodule

// File: rtl/debug_cmd_ctrl.sv
// UART-driven debug controller: decodes command bytes, drives the pipeline
// clock-enable/reset, and requests a debug dump after every command.
module debug_cmd_ctrl
  import debug_pkg::*;
#(
  parameter int         PC_W         = 32,
  parameter int         CNT_W        = 32,
  parameter int         TMO_W        = 24,
  parameter int         RESET_CYCLES = 2,
  parameter logic [7:0] CMD_STEP     = CMD_STEP_DEF,
  parameter logic [7:0] CMD_RUN      = CMD_RUN_DEF,
  parameter logic [7:0] CMD_RESET    = CMD_RESET_DEF,
  parameter logic [7:0] CMD_STEPN    = CMD_STEPN_DEF,
  parameter logic [7:0] CMD_SETBP    = CMD_SETBP_DEF,
  parameter logic [7:0] CMD_CLRBP    = CMD_CLRBP_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  debug_cmd_ctrl_if.slave      uart,
  input  logic                 program_finished,
  input  logic [PC_W-1:0]      pc,
  output logic                 pipe_en,
  output logic                 pipe_reset,
  output logic [2:0]           status,
  output logic [CNT_W-1:0]     cycles_run,
  output logic [3:0]           state
);

  localparam int PC_BYTES = bytes_for(PC_W);
  localparam int AW       = 8 * PC_BYTES;
  localparam int BCW      = $clog2(PC_BYTES + 1);
  localparam int RCW      = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  dbg_state_e       state_q;
  logic [7:0]       cmd_q;
  logic             rd_q;
  logic [2:0]       status_q;
  logic [CNT_W-1:0] cyc_q;
  logic             bp_valid_q;
  logic [PC_W-1:0]  bp_addr_q;
  logic [7:0]       steps_q;
  logic [TMO_W-1:0] tmo_q;
  logic             first_q;
  logic             is_bp_q;
  logic [RCW-1:0]   rcnt_q;

  logic          bp_hit, tmo_hit, run_stop;
  logic          arg_take, arg_done;
  logic [AW-1:0] arg_val;

  // The first RUN cycle skips the breakpoint so a run can resume from it.
  assign bp_hit   = bp_valid_q && (pc == bp_addr_q) && !first_q;
  assign tmo_hit  = &tmo_q;
  assign run_stop = program_finished || bp_hit || tmo_hit;

  always_comb begin
    pipe_en    = 1'b0;
    pipe_reset = 1'b0;
    case (state_q)
      ST_INIT, ST_SOFT_RST: begin
        pipe_en    = 1'b1;
        pipe_reset = 1'b1;
      end
      ST_STEPPING: pipe_en = !program_finished;
      ST_RUNNING:  pipe_en = !run_stop;
      default: ;
    endcase
  end

  // rd_q high means the FIFO head is stale for this cycle.
  assign arg_take = (state_q == ST_ARG) && uart.rx_ready && !rd_q && !arg_done;

  debug_arg_shift #(.NBYTES(PC_BYTES)) u_arg (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == ST_DECODE),
    .shift_i  (arg_take),
    .byte_i   (uart.rx_data),
    .nbytes_i (is_bp_q ? BCW'(PC_BYTES) : BCW'(1)),
    .value_o  (arg_val),
    .done_o   (arg_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      cmd_q      <= '0;
      rd_q       <= 1'b0;
      status_q   <= STAT_OK;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      steps_q    <= '0;
      tmo_q      <= '0;
      first_q    <= 1'b0;
      is_bp_q    <= 1'b0;
      rcnt_q     <= '0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        ST_INIT, ST_SOFT_RST: begin
          if (rcnt_q == RCW'(RESET_CYCLES - 1)) begin
            rcnt_q <= '0;
            if (state_q == ST_INIT) begin
              state_q <= ST_IDLE;
            end else begin
              status_q <= STAT_OK;
              state_q  <= ST_SEND;
            end
          end else begin
            rcnt_q <= rcnt_q + RCW'(1);
          end
        end
        ST_IDLE: begin
          if (uart.rx_ready && !rd_q) begin
            cmd_q   <= uart.rx_data;
            rd_q    <= 1'b1;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (cmd_q)
            CMD_STEP:  begin steps_q <= 8'd1; state_q <= ST_STEPPING; end
            CMD_RUN:   begin tmo_q <= '0; first_q <= 1'b1; state_q <= ST_RUNNING; end
            CMD_RESET: begin rcnt_q <= '0; state_q <= ST_SOFT_RST; end
            CMD_STEPN: begin is_bp_q <= 1'b0; state_q <= ST_ARG; end
            CMD_SETBP: begin is_bp_q <= 1'b1; state_q <= ST_ARG; end
            CMD_CLRBP: begin bp_valid_q <= 1'b0; status_q <= STAT_OK; state_q <= ST_SEND; end
            default:   begin status_q <= STAT_UNKNOWN; state_q <= ST_SEND; end
          endcase
        end
        ST_ARG: begin
          if (arg_done) begin
            if (is_bp_q) begin
              bp_addr_q  <= arg_val[PC_W-1:0];
              bp_valid_q <= 1'b1;
              status_q   <= STAT_OK;
              state_q    <= ST_SEND;
            end else if (arg_val[7:0] == 8'd0) begin
              status_q <= STAT_OK;
              state_q  <= ST_SEND;
            end else begin
              steps_q <= arg_val[7:0];
              state_q <= ST_STEPPING;
            end
          end else if (arg_take) begin
            rd_q <= 1'b1;
          end
        end
        ST_STEPPING: begin
          if (program_finished) begin
            status_q <= STAT_FINISHED;
            state_q  <= ST_SEND;
          end else begin
            steps_q <= steps_q - 8'd1;
            if (steps_q == 8'd1) begin
              status_q <= STAT_OK;
              state_q  <= ST_SEND;
            end
          end
        end
        ST_RUNNING: begin
          if (run_stop) begin
            status_q <= program_finished ? STAT_FINISHED :
                        bp_hit           ? STAT_BREAKPOINT : STAT_TIMEOUT;
            state_q  <= ST_SEND;
          end else begin
            tmo_q   <= tmo_q + TMO_W'(1);
            first_q <= 1'b0;
          end
        end
        ST_SEND: if (uart.tx_done) state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || state_q == ST_INIT || state_q == ST_SOFT_RST)
      cyc_q <= '0;
    else if (pipe_en && !(&cyc_q))
      cyc_q <= cyc_q + CNT_W'(1);
  end

  assign uart.rd_uart  = rd_q;
  assign uart.send_req = (state_q == ST_SEND);
  assign status        = status_q;
  assign cycles_run    = cyc_q;
  assign state         = state_q;

endmodule
